// File: rtl/syn_accum_ctrl_pkg.sv
// Shared widths, FSM encoding and mask helper for the synaptic accumulate controller.
package syn_accum_ctrl_pkg;

    localparam int N_PRE      = 128;
    localparam int PRE_W      = 7;
    localparam int POST_W     = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_W     = POST_W + PRE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Drops the lowest set bit; matches the bit the priority encoder selects.
    function automatic logic [N_PRE-1:0] clear_lowest(input logic [N_PRE-1:0] m);
        return m & (m - {{(N_PRE-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/syn_accum_ctrl_if.sv
// Job request, weight-memory read and MAC accumulate signals of the controller.
interface syn_accum_ctrl_if;
    import syn_accum_ctrl_pkg::*;

    logic                          start_valid;
    logic                          start_ready;
    logic [N_PRE-1:0]              spikes;
    logic [POST_W-1:0]             post_idx;
    logic                          mem_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic signed [DATA_WIDTH-1:0]  mem_rdata;
    logic                          mac_clear;
    logic                          mac_accumulate;
    logic signed [DATA_WIDTH-1:0]  mac_weight;
    logic                          busy;
    logic                          done;

    modport master (
        input  start_valid, spikes, post_idx, mem_rdata,
        output start_ready, mem_en, mem_addr, mac_clear, mac_accumulate, mac_weight, busy, done
    );

    modport slave (
        output start_valid, spikes, post_idx, mem_rdata,
        input  start_ready, mem_en, mem_addr, mac_clear, mac_accumulate, mac_weight, busy, done
    );

endinterface

// File: rtl/syn_accum_ctrl_spike_prio_enc.sv
// Combinational lowest-set-bit encoder over the pending spike mask.
module spike_prio_enc #(
    parameter int N_PRE = 128,
    parameter int PRE_W = $clog2(N_PRE)
) (
    input  logic [N_PRE-1:0] mask,
    output logic [PRE_W-1:0] idx,
    output logic             any_set
);

    always_comb begin
        idx     = '0;
        any_set = |mask;
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = N_PRE - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = PRE_W'(i);
            end
        end
    end

endmodule

// File: rtl/syn_accum_ctrl.sv
// Scans a spike vector, reads one weight per set bit and streams accumulate beats to the MAC.
module syn_accum_ctrl
    import syn_accum_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    syn_accum_ctrl_if.master  bus
);

    state_t            state_reg, state_next;
    logic [N_PRE-1:0]  mask_reg, mask_next, mask_rest;
    logic [POST_W-1:0] post_reg;
    logic              accum_reg;
    logic [PRE_W-1:0]  pre_idx;
    logic              any_set;
    logic              accept;
    logic              mem_en;
    logic              mac_clear;
    logic              done;

    spike_prio_enc #(
        .N_PRE (N_PRE),
        .PRE_W (PRE_W)
    ) u_prio_enc (
        .mask    (mask_reg),
        .idx     (pre_idx),
        .any_set (any_set)
    );

    assign accept    = bus.start_valid && (state_reg == ST_IDLE);
    assign mask_rest = clear_lowest(mask_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            mask_reg  <= '0;
            post_reg  <= '0;
            accum_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            accum_reg <= mem_en;
            if (accept) begin
                post_reg <= bus.post_idx;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        mem_en     = 1'b0;
        mac_clear  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    mask_next  = bus.spikes;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clear  = 1'b1;
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (any_set) begin
                    mem_en    = 1'b1;
                    mask_next = mask_rest;
                    if (mask_rest == '0) begin
                        state_next = ST_DRAIN;
                    end
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            // The last read's data is accumulated during this cycle.
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.start_ready    = (state_reg == ST_IDLE);
    assign bus.busy           = (state_reg != ST_IDLE);
    assign bus.done           = done;
    assign bus.mem_en         = mem_en;
    assign bus.mem_addr       = mem_en ? {post_reg, pre_idx} : '0;
    assign bus.mac_clear      = mac_clear;
    assign bus.mac_accumulate = accum_reg;
    assign bus.mac_weight     = accum_reg ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_syn_accum_ctrl.sv
// Directed bench: controller plus behavioural MAC and 1-cycle weight RAM.
module tb_syn_accum_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    syn_accum_ctrl_if bus ();

    syn_accum_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [7:0]  mem [0:2047];
    logic signed [31:0] sum_r;

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  sum_r <= '0;
        else if (bus.mac_clear)      sum_r <= '0;
        else if (bus.mac_accumulate) sum_r <= sum_r + 32'(bus.mac_weight);
    end

    int cyc = 0;
    int reads = 0, beats = 0, clears = 0, dones = 0, overlaps = 0;
    logic [10:0] addr_log [0:511];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_en) begin
            addr_log[reads % 512] = bus.mem_addr;
            reads++;
        end
        if (bus.mac_accumulate) beats++;
        if (bus.mac_clear) clears++;
        if (bus.done) dones++;
        if (bus.mac_clear && bus.mac_accumulate) overlaps++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic run_job(input string tag, input logic [127:0] spk, input logic [3:0] post,
                           input int exp_sum);
        int k, t0, r0, b0, c0, bad, j;
        k = $countones(spk);
        step();
        bus.start_valid = 1'b1;
        bus.spikes      = spk;
        bus.post_idx    = post;
        t0 = cyc; r0 = reads; b0 = beats; c0 = clears;
        check({tag, "_ready"}, 32'(bus.start_ready), 1);
        step();
        bus.start_valid = 1'b0;
        wait_done();
        check({tag, "_done_lat"}, cyc - t0, ((k == 0) ? 1 : k) + 3);
        check({tag, "_sum"}, sum_r, exp_sum);
        check({tag, "_reads"}, reads - r0, k);
        check({tag, "_beats"}, beats - b0, k);
        check({tag, "_clears"}, clears - c0, 1);
        bad = 0;
        j = r0;
        for (int i = 0; i < 128; i++) begin
            if (spk[i]) begin
                if (addr_log[j % 512] !== {post, 7'(i)}) bad++;
                j++;
            end
        end
        check({tag, "_addr"}, bad, 0);
        $display("job %s k=%0d post=%0d sum=%0d latency=%0d", tag, k, post, sum_r, cyc - t0);
    endtask

    initial begin
        logic [127:0] spk;
        int t0, t1, c0, d0, r0;

        for (int a = 0; a < 2048; a++) mem[a] = 8'sd0;
        mem[11'h185] = -8'sd7;
        for (int i = 0; i < 128; i++) mem[{4'd2, 7'(i)}] = 8'sd127;
        mem[{4'd4, 7'd0}]   = -8'sd128;
        mem[{4'd4, 7'd127}] = -8'sd128;
        mem[{4'd6, 7'd10}]  = 8'sd20;
        mem[{4'd6, 7'd20}]  = -8'sd5;
        mem[{4'd6, 7'd30}]  = 8'sd3;
        for (int i = 0; i < 128; i++) mem[{4'd7, 7'(i)}] = 8'sd1;

        bus.start_valid = 1'b0;
        bus.spikes      = '0;
        bus.post_idx    = '0;

        #2;
        check("rst_ready", 32'(bus.start_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        check("rst_clear", 32'(bus.mac_clear), 0);
        check("rst_acc", 32'(bus.mac_accumulate), 0);
        check("rst_weight", 32'(bus.mac_weight), 0);
        check("rst_done", 32'(bus.done), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        spk = '0; spk[5] = 1'b1;
        run_job("single", spk, 4'd3, -7);

        run_job("zero", 128'd0, 4'd0, 0);

        run_job("all", {128{1'b1}}, 4'd2, 16256);

        spk = '0; spk[0] = 1'b1; spk[127] = 1'b1;
        run_job("sign", spk, 4'd4, -256);

        // start_valid held high through a job and into the next
        step();
        spk = '0; spk[10] = 1'b1; spk[20] = 1'b1;
        bus.start_valid = 1'b1;
        bus.spikes      = spk;
        bus.post_idx    = 4'd6;
        t0 = cyc; c0 = clears;
        wait_done();
        check("hold1_lat", cyc - t0, 5);
        check("hold1_sum", sum_r, 15);
        check("hold1_clears", clears - c0, 1);
        $display("job hold1 sum=%0d latency=%0d", sum_r, cyc - t0);
        spk = '0; spk[10] = 1'b1; spk[30] = 1'b1;
        bus.spikes = spk;
        step();
        check("hold2_ready", 32'(bus.start_ready), 1);
        t1 = cyc;
        step();
        check("hold2_clear", 32'(bus.mac_clear), 1);
        bus.start_valid = 1'b0;
        wait_done();
        check("hold2_lat", cyc - t1, 5);
        check("hold2_sum", sum_r, 23);
        $display("job hold2 sum=%0d latency=%0d", sum_r, cyc - t1);

        // reset in the middle of a scan
        step();
        bus.start_valid = 1'b1;
        bus.spikes      = {128{1'b1}};
        bus.post_idx    = 4'd7;
        step();
        bus.start_valid = 1'b0;
        repeat (5) step();
        check("abort_in_scan", 32'(bus.mem_en), 1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_en", 32'(bus.mem_en), 0);
        check("abort_addr", 32'(bus.mem_addr), 0);
        check("abort_clear", 32'(bus.mac_clear), 0);
        check("abort_acc", 32'(bus.mac_accumulate), 0);
        check("abort_weight", 32'(bus.mac_weight), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_ready", 32'(bus.start_ready), 1);
        check("abort_sum", sum_r, 0);
        d0 = dones; r0 = reads;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        check("abort_no_done", dones - d0, 0);
        check("abort_no_reads", reads - r0, 0);
        check("abort_ready_after", 32'(bus.start_ready), 1);
        $display("abort reset applied mid-scan, dones=%0d reads=%0d", dones - d0, reads - r0);

        spk = '0; spk[1] = 1'b1; spk[2] = 1'b1; spk[3] = 1'b1;
        run_job("fresh", spk, 4'd7, 3);

        check("never_overlap", overlaps, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
